// File: rtl/cv_pkg.sv
// Shared definitions for the composite-video pattern generator.
// Holds the 2-bit pattern mode encodings and the 2-bit luminance levels
// used by the luminance mixer downstream.
package cv_pkg;

  typedef enum logic [1:0] {
    CV_MODE_OFF       = 2'd0,
    CV_MODE_DIAG_DOWN = 2'd1,
    CV_MODE_DIAG_UP   = 2'd2,
    CV_MODE_GRID      = 2'd3
  } cv_mode_e;

  localparam logic [1:0] CV_LUM_BLACK = 2'd0;
  localparam logic [1:0] CV_LUM_GREY  = 2'd2;
  localparam logic [1:0] CV_LUM_WHITE = 2'd3;

endpackage

// File: rtl/cv_pulse_stretch.sv
// Pulse stretcher: turns a single-enable hit into THICKNESS enables of
// activity.
// Ports:
//   clk     in   clock (rising edge)
//   reset   in   synchronous active-high clear of the counter
//   clk_en  in   advance enable; the counter holds while low
//   clr     in   forces the counter to zero on an enabled cycle (blanking)
//   load    in   reloads the counter to THICKNESS on an enabled cycle
//   active  out  high while the counter is nonzero
module cv_pulse_stretch #(
  parameter int THICKNESS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic clr,
  input  logic load,
  output logic active
);

  localparam int CW = $clog2(THICKNESS) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(THICKNESS);

  logic [CW-1:0] out_cnt;

  // clr wins over load so a line never bleeds into blanking; a load while
  // already counting restarts the count rather than extending it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= '0;
    end else if (clk_en) begin
      if (clr) begin
        out_cnt <= '0;
      end else if (load) begin
        out_cnt <= LOAD_VAL;
      end else if (out_cnt != '0) begin
        out_cnt <= out_cnt - CW'(1);
      end
    end
  end

  assign active = (out_cnt != '0);

endmodule

// File: rtl/cv_pattern_gen.sv
// Multi-mode composite-video test pattern generator.
// Draws down/up diagonals or a grid from the timing counters, with
// frame-synchronous mode/scroll changes and a registered 2-bit lum output.
// Ports:
//   clk           in   clock (rising edge)
//   reset         in   synchronous active-high reset
//   en            in   block enable; low clears everything like reset
//   clk_en_pixel  in   pixel-rate enable
//   frame_start   in   one-clk pulse at frame start (not pixel-qualified)
//   x_vis         in   horizontal visible flag
//   x_pos         in   pixel x position
//   y_pos         in   scanline y position
//   mode_sel      in   requested pattern, latched at frame_start
//   scroll_en     in   requested per-frame scroll, latched at frame_start
//   lum           out  registered luminance
module cv_pattern_gen
  import cv_pkg::*;
#(
  parameter int MAX_PIXEL_H      = 1280,
  parameter int MAX_SCANLINES    = 625,
  parameter int THICKNESS_PIXELS = 4,
  parameter int DISTANCE_PIXELS  = 64,
  parameter int LUM              = 3,
  parameter int GRID_LUM         = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             clk_en_pixel,
  input  logic                             frame_start,
  input  logic                             x_vis,
  input  logic [$clog2(MAX_PIXEL_H)-1:0]   x_pos,
  input  logic [$clog2(MAX_SCANLINES)-1:0] y_pos,
  input  logic [1:0]                       mode_sel,
  input  logic                             scroll_en,
  output logic [1:0]                       lum
);

  localparam int DW = $clog2(DISTANCE_PIXELS);
  localparam logic [DW-1:0] D_MAX = DW'(DISTANCE_PIXELS - 1);
  localparam logic [1:0] LINE_LVL = 2'(LUM);
  localparam logic [1:0] ROW_LVL  = 2'(GRID_LUM);

  if (DISTANCE_PIXELS < 2 || (DISTANCE_PIXELS & (DISTANCE_PIXELS - 1)) != 0) begin : g_bad_distance
    $error("cv_pattern_gen: DISTANCE_PIXELS must be a power of 2 and >= 2");
  end
  if (THICKNESS_PIXELS < 1) begin : g_bad_thickness
    $error("cv_pattern_gen: THICKNESS_PIXELS must be >= 1");
  end

  logic           clear;
  logic [DW-1:0]  xt;
  logic [DW-1:0]  yt;
  logic [DW-1:0]  offset;
  cv_mode_e       mode_q;
  logic           scroll_q;
  logic           hit_raw;
  logic           hit;
  logic           row_on;
  logic           line_active;
  logic           unused_pos_bits;

  assign clear = reset | ~en;

  // Only the low log2(D) bits matter: the pattern repeats every D pixels/lines.
  assign xt = x_pos[DW-1:0];
  assign yt = y_pos[DW-1:0];
  assign unused_pos_bits = ^{x_pos, y_pos};

  // Shadow registers update on any frame_start clk, pixel enable or not.
  // The offset step uses the scroll flag latched at the previous frame.
  always_ff @(posedge clk) begin
    if (clear) begin
      mode_q   <= CV_MODE_OFF;
      scroll_q <= 1'b0;
      offset   <= '0;
    end else if (frame_start) begin
      mode_q   <= cv_mode_e'(mode_sel);
      scroll_q <= scroll_en;
      if (scroll_q) begin
        offset <= offset + DW'(1);
      end
    end
  end

  // All sums are DW bits wide, so they wrap mod D naturally.
  always_comb begin
    hit_raw = 1'b0;
    case (mode_q)
      CV_MODE_DIAG_DOWN: hit_raw = (DW'(xt + offset) == yt);
      CV_MODE_DIAG_UP:   hit_raw = (DW'(xt + yt + offset) == D_MAX);
      CV_MODE_GRID:      hit_raw = (DW'(xt + offset) == '0);
      default:           hit_raw = 1'b0;
    endcase
  end

  assign hit = x_vis & hit_raw;

  cv_pulse_stretch #(
    .THICKNESS(THICKNESS_PIXELS)
  ) u_stretch (
    .clk    (clk),
    .reset  (clear),
    .clk_en (clk_en_pixel),
    .clr    (~x_vis),
    .load   (hit),
    .active (line_active)
  );

  // row_on is registered so grid rows share the one-enable latency of lines;
  // line pixels take priority over the row level.
  always_ff @(posedge clk) begin
    if (clear) begin
      row_on <= 1'b0;
      lum    <= CV_LUM_BLACK;
    end else if (clk_en_pixel) begin
      row_on <= (mode_q == CV_MODE_GRID) && (yt == '0) && x_vis;
      if (line_active) begin
        lum <= LINE_LVL;
      end else if (row_on) begin
        lum <= ROW_LVL;
      end else begin
        lum <= CV_LUM_BLACK;
      end
    end
  end

endmodule

// File: tb/tb_cv_pattern_gen.sv
module tb_cv_pattern_gen;

  localparam int T = 4;
  localparam int D = 64;
  localparam int LUMV = 3;
  localparam int GLUM = 2;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clk_en_pixel;
  logic        frame_start;
  logic        x_vis;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [1:0]  mode_sel;
  logic        scroll_en;
  logic [1:0]  lum;

  int total;
  int bad;
  logic [1:0] lum_last;
  logic [1:0] lum_at [0:1279];

  cv_pattern_gen dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clk_en_pixel (clk_en_pixel),
    .frame_start  (frame_start),
    .x_vis        (x_vis),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .mode_sel     (mode_sel),
    .scroll_en    (scroll_en),
    .lum          (lum)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Keeps a short history of pixel enables. lum after enable n is LUM if a
  // hit happened within the last T enables with no blanking enable since,
  // else GRID_LUM if the previous enable was a grid row pixel, else 0.
  typedef struct packed {
    logic vis;
    logic hit;
    logic row;
  } pix_t;

  pix_t hist [$];
  int   m_mode;
  int   m_scroll;
  int   m_off;
  logic [1:0] exp_lum;

  function automatic bit model_hit(input int mode, input int x, input int y,
                                   input int off, input bit vis);
    int xt;
    int yt;
    xt = x % D;
    yt = y % D;
    if (!vis) return 1'b0;
    case (mode)
      1: return ((xt + off) % D) == yt;
      2: return ((xt + yt + off) % D) == D - 1;
      3: return ((xt + off) % D) == 0;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    m_mode = 0;
    m_scroll = 0;
    m_off = 0;
    exp_lum = 2'd0;
  end

  always @(posedge clk) begin : model_p
    logic [1:0] nl;
    pix_t rec;
    int idx;
    if (reset || !en) begin
      hist.delete();
      m_mode = 0;
      m_scroll = 0;
      m_off = 0;
      exp_lum = 2'd0;
    end else begin
      if (clk_en_pixel) begin
        nl = 2'd0;
        for (int i = 0; i < T && i < hist.size(); i++) begin
          idx = hist.size() - 1 - i;
          if (!hist[idx].vis) break;
          if (hist[idx].hit) begin
            nl = 2'(LUMV);
            break;
          end
        end
        if (nl == 2'd0 && hist.size() > 0 && hist[hist.size()-1].row) nl = 2'(GLUM);
        exp_lum = nl;
        rec.vis = x_vis;
        rec.hit = model_hit(m_mode, int'(x_pos), int'(y_pos), m_off, x_vis);
        rec.row = (m_mode == 3) && (int'(y_pos) % D == 0) && x_vis;
        hist.push_back(rec);
        if (hist.size() > T + 1) void'(hist.pop_front());
      end
      if (frame_start) begin
        if (m_scroll != 0) m_off = (m_off + 1) % D;
        m_mode = int'(mode_sel);
        m_scroll = int'(scroll_en);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    total++;
    if (lum !== exp_lum) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t lum=%0d expected=%0d", $time, lum, exp_lum);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  // One pixel = 4 clks, enable on the first; lum_last is lum after that enable.
  task automatic pixel(input int x, input int y, input bit vis);
    @(negedge clk);
    x_pos = 11'(x);
    y_pos = 10'(y);
    x_vis = vis;
    clk_en_pixel = 1'b1;
    @(negedge clk);
    clk_en_pixel = 1'b0;
    lum_last = lum;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sweep(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      pixel(x, y, 1'b1);
      lum_at[x] = lum_last;
    end
  endtask

  task automatic blank(input int n, input int y);
    for (int i = 0; i < n; i++) pixel(1280 + i, y, 1'b0);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int count_lvl(input int x0, input int x1, input int lvl);
    int c;
    c = 0;
    for (int x = x0; x <= x1; x++) if (int'(lum_at[x]) == lvl) c++;
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int xr;
    int yr;
    total = 0;
    bad = 0;
    reset = 1'b1;
    en = 1'b1;
    clk_en_pixel = 1'b0;
    frame_start = 1'b0;
    x_vis = 1'b0;
    x_pos = '0;
    y_pos = '0;
    mode_sel = 2'd0;
    scroll_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_lum", lum, 0);
    reset = 1'b0;

    // DIAG_DOWN, y=10
    mode_sel = 2'd1;
    frame();
    blank(2, 10);
    sweep(10, 0, 1279);
    check("dd_x10", lum_at[10], 0);
    check("dd_x11", lum_at[11], 3);
    check("dd_x14", lum_at[14], 3);
    check("dd_x15", lum_at[15], 0);
    check("dd_x1230", lum_at[1230], 3);
    check("dd_count3", count_lvl(0, 1279, 3), 80);
    blank(2, 10);

    // DIAG_UP, y=0
    do_reset();
    mode_sel = 2'd2;
    frame();
    blank(2, 0);
    sweep(0, 0, 1279);
    check("du_none_0_63", count_lvl(0, 63, 3), 0);
    check("du_x64", lum_at[64], 3);
    check("du_x67", lum_at[67], 3);
    check("du_x68", lum_at[68], 0);
    check("du_count3", count_lvl(0, 1279, 3), 76);
    pixel(1280, 0, 1'b0);
    pixel(1281, 0, 1'b0);
    check("du_blank_after_edge_hit", lum_last, 0);

    // Scroll: offset reaches 2 after 3 frame_starts
    do_reset();
    mode_sel = 2'd1;
    scroll_en = 1'b1;
    frame();
    frame();
    frame();
    scroll_en = 1'b0;
    blank(2, 10);
    sweep(10, 0, 200);
    check("sc_x8", lum_at[8], 0);
    check("sc_x9", lum_at[9], 3);
    check("sc_x12", lum_at[12], 3);
    check("sc_x13", lum_at[13], 0);
    check("sc_x73", lum_at[73], 3);
    check("sc_x76", lum_at[76], 3);

    // GRID
    do_reset();
    mode_sel = 2'd3;
    frame();
    blank(2, 64);
    sweep(64, 0, 1279);
    check("gr_x0", lum_at[0], 0);
    check("gr_x1", lum_at[1], 3);
    check("gr_x4", lum_at[4], 3);
    check("gr_x5", lum_at[5], 2);
    check("gr_count2", count_lvl(1, 1279, 2), 1199);
    check("gr_count3", count_lvl(0, 1279, 3), 80);
    blank(2, 64);
    sweep(65, 0, 1279);
    check("gr65_count2", count_lvl(0, 1279, 2), 0);
    check("gr65_count3", count_lvl(0, 1279, 3), 80);
    blank(2, 65);

    // Mid-line mode change has no effect until frame_start
    do_reset();
    mode_sel = 2'd1;
    frame();
    blank(2, 10);
    sweep(10, 0, 639);
    mode_sel = 2'd0;
    sweep(10, 640, 1279);
    check("mc_x651", lum_at[651], 3);
    check("mc_count3", count_lvl(0, 1279, 3), 80);
    frame();
    blank(1, 10);
    sweep(10, 0, 200);
    check("mc_off_count3", count_lvl(0, 200, 3), 0);

    // reset while lum=3
    do_reset();
    mode_sel = 2'd1;
    frame();
    blank(1, 10);
    sweep(10, 0, 11);
    check("rs_pre", lum_at[11], 3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rs_lum0", lum, 0);
    reset = 1'b0;
    sweep(10, 12, 100);
    check("rs_no_out", count_lvl(12, 100, 3), 0);
    frame();
    blank(1, 10);
    sweep(10, 0, 20);
    check("rs_relatch_x11", lum_at[11], 3);

    // en=0 while lum=3
    blank(1, 10);
    sweep(10, 0, 11);
    check("en_pre", lum_at[11], 3);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_lum0", lum, 0);
    en = 1'b1;
    sweep(10, 12, 100);
    check("en_no_out", count_lvl(12, 100, 3), 0);

    // Randomized phase, checked every cycle against the model
    xr = 0;
    yr = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      clk_en_pixel = ($urandom_range(0, 3) == 0);
      frame_start = ($urandom_range(0, 149) == 0);
      mode_sel = 2'($urandom_range(0, 3));
      scroll_en = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 299) != 0);
      reset = ($urandom_range(0, 599) == 0);
      if (clk_en_pixel) begin
        xr = (xr + 1) % 1400;
        if (xr == 0) yr = $urandom_range(0, 624);
      end
      x_pos = 11'(xr);
      y_pos = 10'(yr);
      x_vis = (xr < 1280) && ($urandom_range(0, 19) != 0);
    end
    @(negedge clk);
    reset = 1'b0;
    en = 1'b1;
    frame_start = 1'b0;
    clk_en_pixel = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
